// File: rtl/regfile_bypass_sb.sv
// Parametrised multi-port register file with write-to-read bypass,
// optional registered read stage and a per-register busy scoreboard.
module regfile_bypass_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int READ_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] src_reg,
  output logic [NUM_RD*DATA_W-1:0] src_data,
  output logic [NUM_RD-1:0]        src_busy,
  input  logic                     write_reg,
  input  logic [ADDR_W-1:0]        dst_reg,
  input  logic [DATA_W-1:0]        dst_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_reg
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DEPTH-1:0]         busy_q;
  logic [DEPTH-1:0]         busy_d;
  logic                     wr_ok;
  logic                     rsv_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_RD-1:0]        hit;
  logic [NUM_RD-1:0]        zero;

  always_comb begin
    wr_ok  = write_reg
          && !(ZERO_REG != 0 && dst_reg == '0);
    rsv_ok = rsv_en
          && !(ZERO_REG != 0 && rsv_reg == '0);
  end

  // Reserve applied after the clear: the new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (write_reg) busy_d[dst_reg] = 1'b0;
    if (rsv_ok)    busy_d[rsv_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_ok) regs_q[dst_reg] <= dst_data;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    hit     = '0;
    zero    = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      hit[k]  = wr_ok
             && dst_reg == src_reg[k*ADDR_W +: ADDR_W];
      zero[k] = ZERO_REG != 0
             && src_reg[k*ADDR_W +: ADDR_W] == '0;
      unique case (1'b1)
        hit[k]:  rd_data[k*DATA_W +: DATA_W] = dst_data;
        zero[k]: rd_data[k*DATA_W +: DATA_W] = '0;
        default: rd_data[k*DATA_W +: DATA_W] =
                   regs_q[src_reg[k*ADDR_W +: ADDR_W]];
      endcase
      if (write_reg
          && dst_reg == src_reg[k*ADDR_W +: ADDR_W])
        rd_busy[k] = 1'b0;
      else
        rd_busy[k] = busy_q[src_reg[k*ADDR_W +: ADDR_W]];
    end
  end

  if (READ_LAT == 1) begin : g_reg
    logic [NUM_RD*DATA_W-1:0] data_out_q;
    logic [NUM_RD-1:0]        busy_out_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_out_q <= '0;
        busy_out_q <= '0;
      end else begin
        data_out_q <= rd_data;
        busy_out_q <= rd_busy;
      end
    end

    assign src_data = data_out_q;
    assign src_busy = busy_out_q;
  end else begin : g_comb
    assign src_data = rd_data;
    assign src_busy = rd_busy;
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Bench for regfile_bypass_sb: comb, registered and 4-port/32-bit
// instances driven in lockstep against a behavioural reference.
module tb_regfile_bypass_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  sa [4];
  logic        wr;
  logic [3:0]  dst;
  logic [31:0] dd;
  logic        rsv;
  logic [3:0]  rreg;

  logic [7:0]   src2;
  logic [15:0]  src4;
  logic [31:0]  d0, d1;
  logic [1:0]   b0, b1;
  logic [127:0] d2;
  logic [3:0]   b2;

  assign src2 = {sa[1], sa[0]};
  assign src4 = {sa[3], sa[2], sa[1], sa[0]};

  regfile_bypass_sb #(
    .DATA_W(16), .ADDR_W(4), .NUM_RD(2),
    .ZERO_REG(1), .READ_LAT(0)
  ) u0 (
    .clk(clk), .rst(rst), .src_reg(src2),
    .src_data(d0), .src_busy(b0),
    .write_reg(wr), .dst_reg(dst),
    .dst_data(dd[15:0]),
    .rsv_en(rsv), .rsv_reg(rreg)
  );

  regfile_bypass_sb #(
    .DATA_W(16), .ADDR_W(4), .NUM_RD(2),
    .ZERO_REG(1), .READ_LAT(1)
  ) u1 (
    .clk(clk), .rst(rst), .src_reg(src2),
    .src_data(d1), .src_busy(b1),
    .write_reg(wr), .dst_reg(dst),
    .dst_data(dd[15:0]),
    .rsv_en(rsv), .rsv_reg(rreg)
  );

  regfile_bypass_sb #(
    .DATA_W(32), .ADDR_W(4), .NUM_RD(4),
    .ZERO_REG(1), .READ_LAT(1)
  ) u2 (
    .clk(clk), .rst(rst), .src_reg(src4),
    .src_data(d2), .src_busy(b2),
    .write_reg(wr), .dst_reg(dst),
    .dst_data(dd),
    .rsv_en(rsv), .rsv_reg(rreg)
  );

  typedef struct packed {
    logic [3:0][31:0] d;
    logic [3:0]       b;
  } exp_t;

  exp_t q[$];
  exp_t e1;
  logic [31:0] mem [16];
  logic [15:0] mbusy;
  int total = 0;
  int bad = 0;

  function automatic logic [31:0] m_data(input logic [3:0] a);
    if (a == 4'd0) return 32'd0;
    if (wr && dst == a) return dd;
    return mem[a];
  endfunction

  function automatic logic m_busy(input logic [3:0] a);
    if (a == 4'd0) return 1'b0;
    if (wr && dst == a) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mbusy = 16'd0;
    q.delete();
    e1 = '0;
  endtask

  task automatic m_clock();
    if (wr && dst != 4'd0) mem[dst] = dd;
    if (wr) mbusy[dst] = 1'b0;
    if (rsv && rreg != 4'd0) mbusy[rreg] = 1'b1;
  endtask

  // Push the sampling-cycle expectation, clock, pop it for the
  // registered instances, then drop the one-shot enables.
  task automatic tick();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.d[k] = m_data(sa[k]);
      e.b[k] = m_busy(sa[k]);
    end
    q.push_back(e);
    m_clock();
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty got=0 exp=1");
    end else begin
      e1 = q.pop_front();
    end
    wr  = 1'b0;
    rsv = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wr = 1'b1; dst = 4'd5; dd = 32'hFFFF_FFFF;
    rsv = 1'b1; rreg = 4'd5;
    sa[0] = 4'd5; sa[1] = 4'd7;
    sa[2] = 4'd9; sa[3] = 4'd0;
    #17;
    total++;
    if (d1 !== 32'd0 || b1 !== 2'b00) begin
      bad++;
      $display("FAIL rst_lat1 got=%h/%b exp=0/0", d1, b1);
    end
    total++;
    if (d2 !== 128'd0 || b2 !== 4'b0000) begin
      bad++;
      $display("FAIL rst_wide got=%h/%b exp=0/0", d2, b2);
    end
    wr = 1'b0; rsv = 1'b0;
    #1;
    total++;
    if (d0 !== 32'd0 || b0 !== 2'b00) begin
      bad++;
      $display("FAIL rst_lat0 got=%h/%b exp=0/0", d0, b0);
    end
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_zero_reg();
    sa[0] = 4'd0; sa[1] = 4'd5;
    wr = 1'b1; dst = 4'd0; dd = 32'h0000_BEEF;
    #1;
    total++;
    if (d0[15:0] !== 16'h0000) begin
      bad++;
      $display("FAIL zero_nobypass got=%h exp=0000", d0[15:0]);
    end
    tick();
    wr = 1'b1; dst = 4'd5; dd = 32'h0000_1234;
    tick();
    #1;
    total++;
    if (d0 !== 32'h1234_0000 || b0 !== 2'b00) begin
      bad++;
      $display("FAIL zero_read got=%h exp=12340000", d0);
    end
    tick();
    total++;
    if (d1 !== 32'h1234_0000
        || d1[15:0] !== e1.d[0][15:0]) begin
      bad++;
      $display("FAIL zero_read_lat1 got=%h exp=12340000", d1);
    end
    rsv = 1'b1; rreg = 4'd0;
    tick();
    #1;
    total++;
    if (b0[0] !== 1'b0) begin
      bad++;
      $display("FAIL zero_rsv got=%b exp=0", b0[0]);
    end
    tick();
    total++;
    if (b1[0] !== 1'b0 || b2[0] !== 1'b0) begin
      bad++;
      $display("FAIL zero_rsv_lat1 got=%b%b exp=00", b1[0], b2[0]);
    end
  endtask

  task automatic test_bypass();
    sa[0] = 4'd3;
    wr = 1'b1; dst = 4'd3; dd = 32'h0000_00AA;
    tick();
    total++;
    if (d1[15:0] !== 16'h00AA) begin
      bad++;
      $display("FAIL byp_setup got=%h exp=00aa", d1[15:0]);
    end
    wr = 1'b1; dst = 4'd3; dd = 32'h0000_5555;
    #1;
    total++;
    if (d0[15:0] !== 16'h5555 || b0[0] !== 1'b0) begin
      bad++;
      $display("FAIL byp_comb got=%h exp=5555", d0[15:0]);
    end
    total++;
    if (d1[15:0] !== 16'h00AA) begin
      bad++;
      $display("FAIL byp_lat1_hold got=%h exp=00aa", d1[15:0]);
    end
    tick();
    total++;
    if (d1[15:0] !== 16'h5555 || b1[0] !== 1'b0
        || d1[15:0] !== e1.d[0][15:0]) begin
      bad++;
      $display("FAIL byp_lat1 got=%h exp=5555", d1[15:0]);
    end
    #1;
    total++;
    if (d0[15:0] !== 16'h5555) begin
      bad++;
      $display("FAIL byp_stored got=%h exp=5555", d0[15:0]);
    end
  endtask

  task automatic test_scoreboard();
    sa[0] = 4'd7;
    rsv = 1'b1; rreg = 4'd7;
    #1;
    total++;
    if (b0[0] !== 1'b0) begin
      bad++;
      $display("FAIL sb_pre got=%b exp=0", b0[0]);
    end
    tick();
    #1;
    total++;
    if (b0[0] !== 1'b1) begin
      bad++;
      $display("FAIL sb_busy got=%b exp=1", b0[0]);
    end
    wr = 1'b1; dst = 4'd7; dd = 32'h0000_0F0F;
    #1;
    total++;
    if (b0[0] !== 1'b0 || d0[15:0] !== 16'h0F0F) begin
      bad++;
      $display("FAIL sb_wcycle got=%b/%h exp=0/0f0f", b0[0], d0[15:0]);
    end
    tick();
    total++;
    if (b1[0] !== 1'b0 || d1[15:0] !== 16'h0F0F) begin
      bad++;
      $display("FAIL sb_lat1 got=%b/%h exp=0/0f0f", b1[0], d1[15:0]);
    end
    #1;
    total++;
    if (b0[0] !== 1'b0) begin
      bad++;
      $display("FAIL sb_clear got=%b exp=0", b0[0]);
    end
  endtask

  task automatic test_rsv_write();
    wr = 1'b1; dst = 4'd9; dd = 32'h0000_ABCD;
    rsv = 1'b1; rreg = 4'd9;
    tick();
    sa[0] = 4'd9;
    #1;
    total++;
    if (d0[15:0] !== 16'hABCD || b0[0] !== 1'b1) begin
      bad++;
      $display("FAIL rw_same got=%h/%b exp=abcd/1", d0[15:0], b0[0]);
    end
    wr = 1'b1; dst = 4'd4; dd = 32'h0000_4444;
    rsv = 1'b1; rreg = 4'd2;
    tick();
    sa[0] = 4'd2; sa[1] = 4'd4;
    #1;
    total++;
    if (b0 !== 2'b01 || d0[31:16] !== 16'h4444) begin
      bad++;
      $display("FAIL rw_diff got=%b/%h exp=01/4444", b0, d0[31:16]);
    end
    rsv = 1'b1; rreg = 4'd2;
    tick();
    #1;
    total++;
    if (b0[0] !== 1'b1) begin
      bad++;
      $display("FAIL rw_rerserve got=%b exp=1", b0[0]);
    end
  endtask

  task automatic test_reset_mid();
    sa[0] = 4'd6; sa[1] = 4'd6;
    wr = 1'b1; dst = 4'd6; dd = 32'h0000_7777;
    rsv = 1'b1; rreg = 4'd6;
    tick();
    tick();
    total++;
    if (d1 !== 32'h7777_7777 || b1 !== 2'b11) begin
      bad++;
      $display("FAIL mid_pre got=%h/%b exp=77777777/11", d1, b1);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (d1 !== 32'd0 || b1 !== 2'b00
        || d2 !== 128'd0 || b2 !== 4'b0000) begin
      bad++;
      $display("FAIL mid_async got=%h/%b exp=0/0", d1, b1);
    end
    total++;
    if (d0 !== 32'd0 || b0 !== 2'b00) begin
      bad++;
      $display("FAIL mid_comb got=%h/%b exp=0/0", d0, b0);
    end
    rst = 1'b1;
    m_reset();
    tick();
    total++;
    if (d1 !== 32'd0 || b1 !== 2'b00) begin
      bad++;
      $display("FAIL mid_after got=%h/%b exp=0/0", d1, b1);
    end
  endtask

  task automatic test_wide();
    logic [31:0] v [4];
    v[0] = 32'h1111_1111; v[1] = 32'h2222_2222;
    v[2] = 32'h3333_3333; v[3] = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      wr = 1'b1; dst = 4'(k + 1); dd = v[k];
      tick();
    end
    rsv = 1'b1; rreg = 4'd3;
    tick();
    for (int k = 0; k < 4; k++) sa[k] = 4'(k + 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (d2[k*32 +: 32] !== v[k]
          || b2[k] !== (k == 2)
          || d2[k*32 +: 32] !== e1.d[k]) begin
        bad++;
        $display("FAIL wide_p%0d got=%h/%b exp=%h/%b",
                 k, d2[k*32 +: 32], b2[k], v[k], k == 2);
      end
    end
    for (int k = 0; k < 4; k++) sa[k] = 4'd2;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if (d2[k*32 +: 32] !== 32'h2222_2222) begin
        bad++;
        $display("FAIL wide_same_p%0d got=%h exp=22222222",
                 k, d2[k*32 +: 32]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ev;
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 4; k++)
        sa[k] = 4'($urandom_range(0, 15));
      wr   = 1'($urandom_range(0, 1));
      dst  = 4'($urandom_range(0, 15));
      dd   = $urandom;
      rsv  = 1'($urandom_range(0, 1));
      rreg = 4'($urandom_range(0, 15));
      #1;
      for (int k = 0; k < 2; k++) begin
        ev = m_data(sa[k]);
        total++;
        if (d0[k*16 +: 16] !== ev[15:0]
            || b0[k] !== m_busy(sa[k])) begin
          bad++;
          $display("FAIL b2b_lat0 n=%0d p%0d got=%h/%b exp=%h/%b",
                   n, k, d0[k*16 +: 16], b0[k], ev[15:0],
                   m_busy(sa[k]));
        end
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (d1[k*16 +: 16] !== e1.d[k][15:0]
            || b1[k] !== e1.b[k]) begin
          bad++;
          $display("FAIL b2b_lat1 n=%0d p%0d got=%h/%b exp=%h/%b",
                   n, k, d1[k*16 +: 16], b1[k],
                   e1.d[k][15:0], e1.b[k]);
        end
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (d2[k*32 +: 32] !== e1.d[k] || b2[k] !== e1.b[k]) begin
          bad++;
          $display("FAIL b2b_wide n=%0d p%0d got=%h/%b exp=%h/%b",
                   n, k, d2[k*32 +: 32], b2[k], e1.d[k], e1.b[k]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_rsv_write();
    test_reset_mid();
    test_wide();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
